// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
//
// Pays out the change owed by the vending controller one coin at a time.
// Coins are chosen greedily: quarter, then dime, then nickel. Each coin uses a
// request/acknowledge handshake with its hopper driver.
//
// A one-cycle `start` strobe loads `amount` while the block is idle or
// faulted. The block then alternates between PICK and EJECT:
//   - PICK is a single decision cycle.
//   - EJECT holds one hopper request high until that hopper answers `ack`.
// The block returns to IDLE with a one-cycle `done` pulse when nothing is
// owed. It parks in FAULT when:
//   - the residue cannot be paid with an available coin, or
//   - a hopper does not answer within EJECT_TIMEOUT cycles.
//
// Optional feature (compile-time macro CHANGE_INVENTORY_EN):
//   defined   - Each hopper has an 8-bit coin count. The count loads INV_INIT
//               at reset and on `refill`, and drops by one per acknowledged
//               coin. PICK skips hoppers whose count is zero.
//   undefined - Every hopper is treated as bottomless. `refill` and INV_INIT
//               have no effect.
//
// Parameters
//   EJECT_TIMEOUT  cycles to wait for `ack` before faulting (>= 2)
//   INV_INIT       coins per hopper after reset / refill (inventory build)
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   start      in   load strobe, honoured only in IDLE or FAULT
//   amount     in   [7:0] change in cents, captured with start
//   ack        in   hopper ejected one coin (single-cycle pulse)
//   refill     in   reload all inventories to INV_INIT
//   eject_q    out  quarter hopper request level
//   eject_d    out  dime hopper request level
//   eject_n    out  nickel hopper request level
//   busy       out  high while in PICK or EJECT
//   done       out  one-cycle pulse when the payout completes
//   fault      out  high while in FAULT
//   remaining  out  [7:0] cents still owed
// ---------------------------------------------------------------------------
module change_dispenser #(
    parameter int unsigned EJECT_TIMEOUT = 1_000_000,
    parameter logic [7:0]  INV_INIT      = 8'd20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] amount,
    input  logic       ack,
    input  logic       refill,
    output logic       eject_q,
    output logic       eject_d,
    output logic       eject_n,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [7:0] remaining
);

    // The timeout counter counts the cycles already spent in EJECT. It runs
    // from 0 to EJECT_TIMEOUT-1, so a request stays up for exactly
    // EJECT_TIMEOUT cycles before the block gives up.
    localparam int unsigned    TW       = $clog2(EJECT_TIMEOUT);
    localparam logic [TW-1:0]  TMO_LAST = TW'(EJECT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        PICK,
        EJECT,
        FAULT
    } state_t;

    typedef enum logic [1:0] {
        COIN_NONE,
        COIN_Q,
        COIN_D,
        COIN_N
    } coin_t;

    state_t        state;
    state_t        next_state;
    coin_t         coin_sel;
    coin_t         coin_sel_next;
    coin_t         pick_coin;
    logic [7:0]    coin_value;
    logic [7:0]    remaining_r;
    logic [7:0]    remaining_next;
    logic          done_r;
    logic          done_next;
    logic [TW-1:0] tmo_cnt;
    logic [TW-1:0] tmo_next;
    logic          tmo_expired;
    logic          avail_q;
    logic          avail_d;
    logic          avail_n;

    assign tmo_expired = (tmo_cnt == TMO_LAST);

`ifdef CHANGE_INVENTORY_EN
    logic [7:0] inv_q;
    logic [7:0] inv_d;
    logic [7:0] inv_n;

    // Per-hopper inventories.
    // Refill takes priority over a decrement landing in the same cycle, so a
    // freshly refilled hopper always reads exactly INV_INIT.
    // PICK never selects an empty hopper, so a decrement cannot wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inv_q <= INV_INIT;
            inv_d <= INV_INIT;
            inv_n <= INV_INIT;
        end else if (refill) begin
            inv_q <= INV_INIT;
            inv_d <= INV_INIT;
            inv_n <= INV_INIT;
        end else if (state == EJECT && ack) begin
            case (coin_sel)
                COIN_Q:  inv_q <= inv_q - 8'd1;
                COIN_D:  inv_d <= inv_d - 8'd1;
                COIN_N:  inv_n <= inv_n - 8'd1;
                default: ;
            endcase
        end
    end

    assign avail_q = (inv_q != 8'd0);
    assign avail_d = (inv_d != 8'd0);
    assign avail_n = (inv_n != 8'd0);
`else
    // Without inventory tracking every hopper is bottomless. The refill input
    // and INV_INIT are kept on the interface so both builds share one pinout.
    logic [8:0] unused_cfg;
    assign unused_cfg = {refill, INV_INIT};

    assign avail_q = 1'b1;
    assign avail_d = 1'b1;
    assign avail_n = 1'b1;
`endif

    // Greedy coin choice for the current residue.
    // It is only acted on in PICK, but it is evaluated every cycle so that
    // the PICK decision is a plain function of the registered remaining
    // amount.
    always_comb begin
        pick_coin = COIN_NONE;
        if (remaining_r >= 8'd25 && avail_q) begin
            pick_coin = COIN_Q;
        end else if (remaining_r >= 8'd10 && avail_d) begin
            pick_coin = COIN_D;
        end else if (remaining_r >= 8'd5 && avail_n) begin
            pick_coin = COIN_N;
        end
    end

    // Face value, in cents, of the coin currently being ejected.
    always_comb begin
        case (coin_sel)
            COIN_Q:  coin_value = 8'd25;
            COIN_D:  coin_value = 8'd10;
            COIN_N:  coin_value = 8'd5;
            default: coin_value = 8'd0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    // In EJECT an ack is checked before the timeout, so a coin that arrives
    // on the last permitted cycle still counts.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, FAULT: begin
                if (start) begin
                    next_state = PICK;
                end
            end
            PICK: begin
                if (remaining_r == 8'd0) begin
                    next_state = IDLE;
                end else if (pick_coin != COIN_NONE) begin
                    next_state = EJECT;
                end else begin
                    next_state = FAULT;
                end
            end
            EJECT: begin
                if (ack) begin
                    next_state = PICK;
                end else if (tmo_expired) begin
                    next_state = FAULT;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Next values for the datapath registers: owed amount, selected coin,
    // done pulse and timeout counter.
    // Leaving EJECT by ack or by timeout clears the coin selection, so the
    // request drops on the same edge.
    always_comb begin
        remaining_next = remaining_r;
        coin_sel_next  = coin_sel;
        done_next      = 1'b0;
        tmo_next       = tmo_cnt;
        case (state)
            IDLE, FAULT: begin
                if (start) begin
                    remaining_next = amount;
                end
            end
            PICK: begin
                coin_sel_next = pick_coin;
                tmo_next      = '0;
                done_next     = (remaining_r == 8'd0);
            end
            EJECT: begin
                if (ack) begin
                    remaining_next = remaining_r - coin_value;
                    coin_sel_next  = COIN_NONE;
                    tmo_next       = '0;
                end else if (tmo_expired) begin
                    coin_sel_next  = COIN_NONE;
                end else begin
                    tmo_next       = tmo_cnt + TW'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers. Everything clears to zero on reset, so any request
    // in flight drops as soon as reset rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining_r <= 8'd0;
            coin_sel    <= COIN_NONE;
            done_r      <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            remaining_r <= remaining_next;
            coin_sel    <= coin_sel_next;
            done_r      <= done_next;
            tmo_cnt     <= tmo_next;
        end
    end

    // Output decode.
    // Every output comes straight from registered state, so the hopper
    // requests are glitch-free. At most one request can be high because
    // coin_sel holds a single value.
    always_comb begin
        eject_q   = (state == EJECT) && (coin_sel == COIN_Q);
        eject_d   = (state == EJECT) && (coin_sel == COIN_D);
        eject_n   = (state == EJECT) && (coin_sel == COIN_N);
        busy      = (state == PICK) || (state == EJECT);
        fault     = (state == FAULT);
        done      = done_r;
        remaining = remaining_r;
    end

    // The hopper drivers rely on never seeing two requests at once.
    a_one_request: assert property (
        @(posedge clk) disable iff (reset) $onehot0({eject_q, eject_d, eject_n})
    );

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Sequences payout of the change amount computed by the vending controller. A one-cycle `start` strobe loads the owed amount. The block then drives three coin hoppers (25¢, 10¢, 5¢) one coin at a time, using greedy selection and a request/acknowledge handshake per coin. It sits between the vending FSM's change register and the hopper drivers, and reports completion or fault back to the vending FSM.

## Interface
- `EJECT_TIMEOUT`, default 1_000_000: cycles to wait for `ack` before faulting (≥2).
- `INV_INIT`, default 8'd20: coins loaded into each hopper at reset/refill (inventory build only).
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `start`  in  1  load strobe; sampled only in IDLE or FAULT.
- `amount`  in  8  change in cents, captured with `start`.
- `ack`  in  1  hopper ejected one coin; single-cycle pulse.
- `refill`  in  1  reload all inventories to `INV_INIT` (ignored without macro).
- `eject_q`, `eject_d`, `eject_n`  out  1 each  per-hopper request level; at most one high.
- `busy`  out  1  high in PICK/EJECT.
- `done`  out  1  one-cycle pulse: payout complete.
- `fault`  out  1  high in FAULT; clears on next accepted `start` or reset.
- `remaining`  out  8  cents still owed.

## Operation
- States: IDLE, PICK, EJECT, FAULT. Reset → IDLE. All outputs are 0 and all counters are 0 during reset; inventories are `INV_INIT`.
- IDLE/FAULT + `start`:
  - `remaining` ← `amount`.
  - `fault` ← 0.
  - Go to PICK.
- PICK makes a single-cycle decision. Quarter available means inventory > 0, or always available without the macro; the same rule applies to dimes and nickels.
  - `remaining` == 0 → IDLE; pulse `done`.
  - `remaining` ≥ 25 and quarter available → EJECT; `eject_q`=1.
  - Else `remaining` ≥ 10 and dime available → EJECT; `eject_d`=1.
  - Else `remaining` ≥ 5 and nickel available → EJECT; `eject_n`=1.
  - Else → FAULT. `remaining` holds the unpaid residue.
- EJECT:
  - The request stays high until `ack`.
  - On `ack`:
    - `remaining` -= coin value (unsigned 8-bit; never underflows by construction).
    - The selected inventory decrements.
    - The request drops.
    - Go to PICK.
  - The timeout counter resets on EJECT entry. If it reaches `EJECT_TIMEOUT` with no `ack` → FAULT: request drops, `remaining` unchanged.
- `ack` outside EJECT is ignored. `start` in PICK/EJECT is ignored.
- `ack` and timeout expiry in the same cycle: `ack` wins.
- `refill`:
  - In any state, reloads inventories the next edge.
  - If it coincides with an `ack` decrement, refill wins.
  - Does not clear `fault`.
- Amounts that are not multiples of 5 always end in FAULT with `remaining` in 1..4.

## Timing
- `start` at edge k → `busy`=1 after edge k.
- Request asserted after edge k+1: one PICK cycle, registered output.
- `ack` sampled at edge m → request low and `remaining` updated after edge m. PICK occupies the following cycle, so the next request comes after edge m+1. There is a minimum of one idle cycle between consecutive requests.
- `amount`=0: `done` high in the cycle after edge k+1; `busy` low in that same cycle.
- Per-coin throughput: 2 cycles plus hopper latency.
- Reset mid-EJECT: request drops immediately (asynchronous); no `done` and no `fault`.

## Configuration
- `CHANGE_INVENTORY_EN` defined:
  - Per-hopper 8-bit inventory counters are present.
  - Exhausted hoppers are skipped by PICK.
  - `refill` is honored.
- `CHANGE_INVENTORY_EN` undefined:
  - No counters; every coin is always available.
  - `refill` is ignored.
  - `INV_INIT` is unused.

## Test plan
- `amount`=40, `ack` 3 cycles after each request → `eject_q`, `eject_d`, `eject_n` in order. `remaining` goes 40→15→5→0, then one `done` pulse and `fault`=0.
- `amount`=0 → no request, `done` exactly 2 cycles after `start`, `busy` high for one cycle.
- `amount`=7 → one `eject_n`; after `ack`, FAULT with `remaining`=2. Then `start` with `amount`=10 → `fault` clears, one `eject_d`, `done`.
- `amount`=25, `EJECT_TIMEOUT`=16, no `ack` → `eject_q` high for 16 cycles, then `fault`=1, `remaining`=25, all requests low.
- `CHANGE_INVENTORY_EN`, quarter inventory preset to 1, `amount`=50 → Q, D, D, N; quarter inventory 0. After `refill`, `amount`=25 → single Q.
- `reset` asserted while `eject_d` is high → all outputs 0 immediately, state IDLE, and a later `ack` is ignored.
